// File: rtl/rt_pkg.sv
// Shared types and width helpers for the reaction-time game controller.
package rt_pkg;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_WAIT    = 3'd1;
    localparam logic [2:0] ST_CLR1    = 3'd2;
    localparam logic [2:0] ST_MEASURE = 3'd3;
    localparam logic [2:0] ST_STORE   = 3'd4;
    localparam logic [2:0] ST_CLR2    = 3'd5;
    localparam logic [2:0] ST_AVERAGE = 3'd6;
    localparam logic [2:0] ST_COMPARE = 3'd7;

    typedef enum logic [2:0] {
        S_IDLE    = ST_IDLE,
        S_WAIT    = ST_WAIT,
        S_CLR1    = ST_CLR1,
        S_MEASURE = ST_MEASURE,
        S_STORE   = ST_STORE,
        S_CLR2    = ST_CLR2,
        S_AVERAGE = ST_AVERAGE,
        S_COMPARE = ST_COMPARE
    } state_e;

    function automatic int time_max(input int time_w);
        return (1 << time_w) - 1;
    endfunction

    function automatic int sum_w(input int time_w, input int rounds_log2);
        return time_w + rounds_log2;
    endfunction

endpackage

// File: rtl/reaction_test_fsm_if.sv
// Button/timer events in, game state and per-player results out.
interface reaction_test_fsm_if
    import rt_pkg::*;
#(
    parameter int NUM_PLAYERS = 2,
    parameter int ROUNDS_LOG2 = 3,
    parameter int TIME_W      = 10,
    parameter int IN_W        = 16
);
    localparam int PW     = $clog2(NUM_PLAYERS);
    localparam int SUM_W  = sum_w(TIME_W, ROUNDS_LOG2);
    localparam int TURN_W = ROUNDS_LOG2 + 1;

    logic [PW-1:0]                 cur_player;
    logic                          btn_action;
    logic                          btn_react;
    logic                          btn_average;
    logic                          btn_compare;
    logic                          evt_start;
    logic                          evt_overflow;
    logic                          evt_cleared;
    logic [IN_W-1:0]               react_time;
    logic [2:0]                    state;
    logic [NUM_PLAYERS*SUM_W-1:0]  sum_flat;
    logic [NUM_PLAYERS*TIME_W-1:0] avg_flat;
    logic [NUM_PLAYERS*TURN_W-1:0] turn_flat;
    logic [NUM_PLAYERS-1:0]        done_mask;
    logic [PW-1:0]                 winner;
    logic                          winner_valid;
    logic                          tie;

    modport master (
        output cur_player, btn_action, btn_react, btn_average, btn_compare,
        output evt_start, evt_overflow, evt_cleared, react_time,
        input  state, sum_flat, avg_flat, turn_flat, done_mask,
        input  winner, winner_valid, tie
    );

    modport slave (
        input  cur_player, btn_action, btn_react, btn_average, btn_compare,
        input  evt_start, evt_overflow, evt_cleared, react_time,
        output state, sum_flat, avg_flat, turn_flat, done_mask,
        output winner, winner_valid, tie
    );

endinterface

// File: rtl/rt_argmin.sv
// Combinational argmin over packed player sums; lowest index wins ties.
module rt_argmin #(
    parameter int NUM_PLAYERS = 2,
    parameter int SUM_W       = 13
) (
    input  logic [NUM_PLAYERS*SUM_W-1:0]     sum_flat,
    output logic [$clog2(NUM_PLAYERS)-1:0]   idx,
    output logic                             tie
);
    localparam int PW = $clog2(NUM_PLAYERS);

    logic [SUM_W-1:0] best;
    logic [SUM_W-1:0] s;

    always_comb begin
        best = sum_flat[0 +: SUM_W];
        idx  = '0;
        tie  = 1'b0;
        s    = '0;
        for (int p = 1; p < NUM_PLAYERS; p++) begin
            s = sum_flat[p*SUM_W +: SUM_W];
            if (s < best) begin
                best = s;
                idx  = PW'(p);
                tie  = 1'b0;
            end else if (s == best) begin
                tie = 1'b1;
            end
        end
    end

endmodule

// File: rtl/reaction_test_fsm.sv
// Reaction-time game controller: round sequencing, per-player
// accumulation with saturation and false-start penalty, final ranking.
module reaction_test_fsm
    import rt_pkg::*;
#(
    parameter int NUM_PLAYERS = 2,
    parameter int ROUNDS_LOG2 = 3,
    parameter int TIME_W      = 10,
    parameter int IN_W        = 16
) (
    input  logic                clk,
    input  logic                rstn,
    reaction_test_fsm_if.slave  bus
);
    localparam int PW     = $clog2(NUM_PLAYERS);
    localparam int SUM_W  = sum_w(TIME_W, ROUNDS_LOG2);
    localparam int TURN_W = ROUNDS_LOG2 + 1;
    localparam int ROUNDS = 1 << ROUNDS_LOG2;
    localparam logic [TIME_W-1:0] TMAX = TIME_W'(time_max(TIME_W));

    state_e              state_q, state_d;
    logic [SUM_W-1:0]    sum_q  [NUM_PLAYERS];
    logic [SUM_W-1:0]    sum_d  [NUM_PLAYERS];
    logic [TURN_W-1:0]   turn_q [NUM_PLAYERS];
    logic [TURN_W-1:0]   turn_d [NUM_PLAYERS];
    logic [PW-1:0]       win_q, win_d;
    logic                tie_q, tie_d;

    logic                         cur_ok;
    logic [TURN_W-1:0]            cur_turn;
    logic                         cur_full;
    logic                         cur_open;
    logic                         acc;
    logic [TIME_W-1:0]            sample;
    logic [TIME_W-1:0]            in_cap;
    logic [NUM_PLAYERS-1:0]       done;
    logic [NUM_PLAYERS*SUM_W-1:0] sum_flat_w;
    logic [NUM_PLAYERS*TIME_W-1:0] avg_flat_w;
    logic [NUM_PLAYERS*TURN_W-1:0] turn_flat_w;
    logic [PW-1:0]                am_idx;
    logic                         am_tie;

    // An out-of-range player matches no slot and so never accumulates.
    always_comb begin
        cur_ok   = 1'b0;
        cur_turn = '0;
        for (int p = 0; p < NUM_PLAYERS; p++) begin
            if (bus.cur_player == PW'(p)) begin
                cur_ok   = 1'b1;
                cur_turn = turn_q[p];
            end
        end
    end

    assign cur_full = cur_ok && (cur_turn == TURN_W'(ROUNDS));
    assign cur_open = cur_ok && (cur_turn != TURN_W'(ROUNDS));
    assign in_cap   = (bus.react_time > IN_W'(TMAX)) ? TMAX
                    : bus.react_time[TIME_W-1:0];

    always_comb begin
        state_d = state_q;
        sum_d   = sum_q;
        turn_d  = turn_q;
        win_d   = win_q;
        tie_d   = tie_q;
        acc     = 1'b0;
        sample  = TMAX;
        case (state_q)
            S_IDLE: begin
                for (int p = 0; p < NUM_PLAYERS; p++) begin
                    sum_d[p]  = '0;
                    turn_d[p] = '0;
                end
                if (bus.btn_action) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (bus.btn_react) begin
                    acc     = 1'b1;
                    state_d = S_STORE;
                end else if (bus.evt_start) begin
                    state_d = S_CLR1;
                end
            end
            S_CLR1: if (bus.evt_cleared) state_d = S_MEASURE;
            S_MEASURE: begin
                if (bus.evt_overflow) begin
                    acc     = 1'b1;
                    state_d = S_STORE;
                end else if (bus.btn_react) begin
                    acc     = 1'b1;
                    sample  = in_cap;
                    state_d = S_STORE;
                end
            end
            S_STORE: begin
                if (cur_full && bus.btn_average) state_d = S_AVERAGE;
                else if (cur_open && bus.btn_action) state_d = S_CLR2;
            end
            S_CLR2: if (bus.evt_cleared) state_d = S_WAIT;
            S_AVERAGE: begin
                if ((&done) && bus.btn_compare) begin
                    state_d = S_COMPARE;
                    win_d   = am_idx;
                    tie_d   = am_tie;
                end else if (cur_open && bus.btn_action) begin
                    state_d = S_WAIT;
                end
            end
            S_COMPARE: if (bus.btn_action) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (acc && cur_open) begin
            for (int p = 0; p < NUM_PLAYERS; p++) begin
                if (bus.cur_player == PW'(p)) begin
                    sum_d[p]  = sum_q[p] + SUM_W'(sample);
                    turn_d[p] = turn_q[p] + TURN_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_IDLE;
            win_q   <= '0;
            tie_q   <= 1'b0;
            for (int p = 0; p < NUM_PLAYERS; p++) begin
                sum_q[p]  <= '0;
                turn_q[p] <= '0;
            end
        end else begin
            state_q <= state_d;
            win_q   <= win_d;
            tie_q   <= tie_d;
            for (int p = 0; p < NUM_PLAYERS; p++) begin
                sum_q[p]  <= sum_d[p];
                turn_q[p] <= turn_d[p];
            end
        end
    end

    always_comb begin
        sum_flat_w  = '0;
        avg_flat_w  = '0;
        turn_flat_w = '0;
        done        = '0;
        for (int p = 0; p < NUM_PLAYERS; p++) begin
            sum_flat_w[p*SUM_W +: SUM_W]    = sum_q[p];
            avg_flat_w[p*TIME_W +: TIME_W]  = sum_q[p][SUM_W-1:ROUNDS_LOG2];
            turn_flat_w[p*TURN_W +: TURN_W] = turn_q[p];
            done[p] = (turn_q[p] == TURN_W'(ROUNDS));
        end
    end

    rt_argmin #(
        .NUM_PLAYERS (NUM_PLAYERS),
        .SUM_W       (SUM_W)
    ) u_argmin (
        .sum_flat (sum_flat_w),
        .idx      (am_idx),
        .tie      (am_tie)
    );

    assign bus.state        = state_q;
    assign bus.sum_flat     = sum_flat_w;
    assign bus.avg_flat     = avg_flat_w;
    assign bus.turn_flat    = turn_flat_w;
    assign bus.done_mask    = done;
    assign bus.winner       = win_q;
    assign bus.tie          = tie_q;
    assign bus.winner_valid = (state_q == S_COMPARE);

endmodule

// File: tb/tb_reaction_test_fsm.sv
// Directed bench for reaction_test_fsm with two players and eight rounds.
module tb_reaction_test_fsm;
    localparam int NP  = 2;
    localparam int RL  = 3;
    localparam int TW  = 10;
    localparam int IW  = 16;
    localparam int SW  = TW + RL;
    localparam int TNW = RL + 1;

    localparam int M_A  = 1;
    localparam int M_R  = 2;
    localparam int M_AV = 4;
    localparam int M_C  = 8;
    localparam int M_ST = 16;
    localparam int M_OV = 32;
    localparam int M_CL = 64;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    int   n_tests = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    reaction_test_fsm_if #(
        .NUM_PLAYERS (NP), .ROUNDS_LOG2 (RL), .TIME_W (TW), .IN_W (IW)
    ) bus ();

    reaction_test_fsm #(
        .NUM_PLAYERS (NP), .ROUNDS_LOG2 (RL), .TIME_W (TW), .IN_W (IW)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    function automatic logic [31:0] sum_of(input int p);
        return 32'(bus.sum_flat[p*SW +: SW]);
    endfunction

    function automatic logic [31:0] turn_of(input int p);
        return 32'(bus.turn_flat[p*TNW +: TNW]);
    endfunction

    function automatic logic [31:0] avg_of(input int p);
        return 32'(bus.avg_flat[p*TW +: TW]);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic clear_in();
        bus.btn_action   = 1'b0;
        bus.btn_react    = 1'b0;
        bus.btn_average  = 1'b0;
        bus.btn_compare  = 1'b0;
        bus.evt_start    = 1'b0;
        bus.evt_overflow = 1'b0;
        bus.evt_cleared  = 1'b0;
        bus.react_time   = '0;
    endtask

    task automatic step(input int m, input int t);
        bus.btn_action   = m[0];
        bus.btn_react    = m[1];
        bus.btn_average  = m[2];
        bus.btn_compare  = m[3];
        bus.evt_start    = m[4];
        bus.evt_overflow = m[5];
        bus.evt_cleared  = m[6];
        bus.react_time   = IW'(t);
        @(posedge clk);
        #1;
        clear_in();
    endtask

    task automatic rnd(input int t);
        step(M_ST, 0);
        step(M_CL, 0);
        step(M_R, t);
    endtask

    task automatic nxt();
        step(M_A, 0);
        step(M_CL, 0);
    endtask

    task automatic play8(input int t);
        for (int i = 0; i < 8; i++) begin
            rnd(t);
            if (i < 7) nxt();
        end
    endtask

    task automatic game(input int t0, input int t1);
        bus.cur_player = 1'b0;
        step(M_A, 0);
        play8(t0);
        step(M_AV, 0);
        bus.cur_player = 1'b1;
        step(M_A, 0);
        play8(t1);
        step(M_AV, 0);
        step(M_C, 0);
    endtask

    initial begin
        clear_in();
        bus.cur_player = 1'b0;
        rstn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_state", 32'(bus.state), 0);
        chk("rst_sums", 32'(bus.sum_flat), 0);
        chk("rst_turns", 32'(bus.turn_flat), 0);
        chk("rst_winner", 32'(bus.winner), 0);
        chk("rst_valid", 32'(bus.winner_valid), 0);
        chk("rst_tie", 32'(bus.tie), 0);
        rstn = 1'b1;
        step(0, 0);
        chk("idle_hold", 32'(bus.state), 0);

        // Game 1: P0 steady 200 ms, P1 overflow / saturation / false start
        step(M_A, 0);
        chk("to_wait", 32'(bus.state), 1);
        rnd(200);
        chk("r1_state", 32'(bus.state), 4);
        chk("r1_sum0", sum_of(0), 200);
        chk("r1_turn0", turn_of(0), 1);
        nxt();
        chk("back_wait", 32'(bus.state), 1);
        for (int i = 1; i < 8; i++) begin
            rnd(200);
            if (i < 7) nxt();
        end
        chk("p0_state", 32'(bus.state), 4);
        chk("p0_sum", sum_of(0), 1600);
        chk("p0_turn", turn_of(0), 8);
        chk("p0_avg", avg_of(0), 200);
        chk("p0_done", 32'(bus.done_mask), 1);
        step(M_AV, 0);
        chk("to_avg", 32'(bus.state), 6);
        step(M_C, 0);
        chk("cmp_ignored", 32'(bus.state), 6);
        chk("cmp_ign_valid", 32'(bus.winner_valid), 0);

        bus.cur_player = 1'b1;
        step(M_A, 0);
        chk("p1_wait", 32'(bus.state), 1);
        step(M_ST, 0);
        step(M_CL, 0);
        step(M_OV, 0);
        chk("ovf_sum1", sum_of(1), 1023);
        chk("ovf_turn1", turn_of(1), 1);
        nxt();
        rnd(5000);
        chk("sat_sum1", sum_of(1), 2046);
        chk("sat_turn1", turn_of(1), 2);
        nxt();
        step(M_R | M_ST, 0);
        chk("fs_state", 32'(bus.state), 4);
        chk("fs_sum1", sum_of(1), 3069);
        chk("fs_turn1", turn_of(1), 3);
        nxt();
        for (int i = 0; i < 5; i++) begin
            rnd(0);
            if (i < 4) nxt();
        end
        chk("p1_done", 32'(bus.done_mask), 3);
        step(M_AV, 0);
        step(M_C, 0);
        chk("g1_state", 32'(bus.state), 7);
        chk("g1_winner", 32'(bus.winner), 0);
        chk("g1_tie", 32'(bus.tie), 0);
        chk("g1_valid", 32'(bus.winner_valid), 1);
        step(M_A, 0);
        chk("g1_idle", 32'(bus.state), 0);
        chk("g1_valid_drop", 32'(bus.winner_valid), 0);
        step(0, 0);
        chk("g1_sums_clr", 32'(bus.sum_flat), 0);
        chk("g1_turns_clr", 32'(bus.turn_flat), 0);

        // Game 2: P1 faster
        game(200, 150);
        chk("g2_sum1", sum_of(1), 1200);
        chk("g2_state", 32'(bus.state), 7);
        chk("g2_winner", 32'(bus.winner), 1);
        chk("g2_tie", 32'(bus.tie), 0);
        step(M_A, 0);
        step(0, 0);

        // Game 3: equal sums
        game(200, 200);
        chk("g3_winner", 32'(bus.winner), 0);
        chk("g3_tie", 32'(bus.tie), 1);
        chk("g3_valid", 32'(bus.winner_valid), 1);
        step(M_A, 0);
        step(0, 0);

        // Asynchronous reset while measuring
        bus.cur_player = 1'b0;
        step(M_A, 0);
        for (int i = 0; i < 4; i++) begin
            rnd(200);
            nxt();
        end
        step(M_ST, 0);
        step(M_CL, 0);
        chk("mr_state", 32'(bus.state), 3);
        chk("mr_sum0", sum_of(0), 800);
        #2;
        rstn = 1'b0;
        #1;
        chk("ar_state", 32'(bus.state), 0);
        chk("ar_sums", 32'(bus.sum_flat), 0);
        chk("ar_turns", 32'(bus.turn_flat), 0);
        chk("ar_tie", 32'(bus.tie), 0);
        chk("ar_winner", 32'(bus.winner), 0);
        @(posedge clk);
        #1;
        rstn = 1'b1;
        step(M_A, 0);
        chk("post_wait", 32'(bus.state), 1);
        rnd(100);
        chk("post_sum0", sum_of(0), 100);
        chk("post_turn0", turn_of(0), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
